// File: rtl/mem_scheduler_pkg.sv
// Shared types and constants for the three-way memory port scheduler.
package mem_scheduler_pkg;

  localparam int mem_sched_starve_limit = 8;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;

  typedef enum logic {IDLE, BUSY} sched_state_type;

  localparam logic [1:0] OWNER_DMEM = 2'd0;
  localparam logic [1:0] OWNER_IMEM = 2'd1;
  localparam logic [1:0] OWNER_AUX  = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

endpackage

// File: rtl/mem_scheduler_if.sv
// Requester buses plus the single external memory port, seen from the scheduler (master) and its surroundings (slave).
interface mem_scheduler_if;
  import mem_scheduler_pkg::*;

  mem_in_type  dmem_in, imem_in, aux_in;
  mem_out_type dmem_out, imem_out, aux_out;
  logic        memory_valid;
  logic        memory_instr;
  logic [31:0] memory_addr;
  logic [31:0] memory_wdata;
  logic [3:0]  memory_wstrb;
  logic [31:0] memory_rdata;
  logic        memory_ready;
  logic [1:0]  grant_owner;
  logic        overflow;

  modport master (
    input  dmem_in, imem_in, aux_in, memory_rdata, memory_ready,
    output dmem_out, imem_out, aux_out, memory_valid, memory_instr,
           memory_addr, memory_wdata, memory_wstrb, grant_owner, overflow
  );

  modport slave (
    output dmem_in, imem_in, aux_in, memory_rdata, memory_ready,
    input  dmem_out, imem_out, aux_out, memory_valid, memory_instr,
           memory_addr, memory_wdata, memory_wstrb, grant_owner, overflow
  );

endinterface

// File: rtl/mem_sched_select.sv
// Winner selection: urgent candidates beat non-urgent ones, then dmem > imem > aux.
module mem_sched_select
  import mem_scheduler_pkg::*;
(
  input  logic [2:0] candidate,
  input  logic [1:0] urgent,
  output logic [2:0] grant,
  output logic [1:0] owner
);

  logic [2:0] urgent_cand;
  logic [2:0] pool;

  // dmem can never be urgent, so only imem/aux bits are masked in
  always_comb begin
    urgent_cand = candidate & {urgent, 1'b0};
    pool        = (urgent_cand != 3'b000) ? urgent_cand : candidate;
    grant       = 3'b000;
    owner       = OWNER_NONE;
    if (pool[0]) begin
      grant = 3'b001;
      owner = OWNER_DMEM;
    end else if (pool[1]) begin
      grant = 3'b010;
      owner = OWNER_IMEM;
    end else if (pool[2]) begin
      grant = 3'b100;
      owner = OWNER_AUX;
    end
  end

endmodule

// File: rtl/mem_scheduler.sv
// Shares one memory port among dmem, imem and aux with one transaction outstanding and starvation aging.
module mem_scheduler
  import mem_scheduler_pkg::*;
#(
  parameter int STARVE_LIMIT = mem_sched_starve_limit
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_scheduler_if.master bus
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT_CNT = CW'(STARVE_LIMIT);

  sched_state_type state, state_next;
  mem_in_type      req_in   [3];
  mem_in_type      pend_req [3];
  mem_in_type      cand_req [3];
  mem_in_type      cur;
  mem_in_type      win_req;
  mem_out_type     port_out [3];
  logic [CW-1:0]   wait_cnt [2];
  logic [1:0]      owner;
  logic [1:0]      win_owner;
  logic [2:0]      clear, eff_pend, candidate, grant;
  logic [1:0]      urgent;
  logic            done, arb, load, overflow;

  assign req_in[0] = bus.dmem_in;
  assign req_in[1] = bus.imem_in;
  assign req_in[2] = bus.aux_in;

  // A slot whose owner completes this cycle counts as empty, so a same-cycle re-pulse is a fresh request
  always_comb begin
    done = (state == BUSY) && bus.memory_ready;
    for (int i = 0; i < 3; i++) begin
      clear[i]     = done && (owner == 2'(i));
      eff_pend[i]  = pend_req[i].mem_valid && !clear[i];
      cand_req[i]  = eff_pend[i] ? pend_req[i] : req_in[i];
      candidate[i] = cand_req[i].mem_valid;
    end
    urgent[0] = (STARVE_LIMIT != 0) && (wait_cnt[0] == LIMIT_CNT);
    urgent[1] = (STARVE_LIMIT != 0) && (wait_cnt[1] == LIMIT_CNT);
  end

  mem_sched_select u_select (
    .candidate (candidate),
    .urgent    (urgent),
    .grant     (grant),
    .owner     (win_owner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    arb        = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE:    arb = 1'b1;
      BUSY:    arb = bus.memory_ready;
      default: arb = 1'b0;
    endcase
    if (arb) begin
      load       = |candidate;
      state_next = load ? BUSY : IDLE;
    end
    case (win_owner)
      OWNER_IMEM: win_req = cand_req[1];
      OWNER_AUX:  win_req = cand_req[2];
      default:    win_req = cand_req[0];
    endcase
  end

  // cur.mem_valid doubles as memory_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= '0;
      owner <= OWNER_NONE;
    end else if (arb) begin
      if (load) begin
        cur   <= win_req;
        owner <= win_owner;
      end else begin
        cur.mem_valid <= 1'b0;
        owner         <= OWNER_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pend_req[i] <= '0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (clear[i]) pend_req[i].mem_valid <= 1'b0;
        if (req_in[i].mem_valid) begin
          if (eff_pend[i]) overflow <= 1'b1;
          else             pend_req[i] <= req_in[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt[0] <= '0;
      wait_cnt[1] <= '0;
    end else if (load) begin
      for (int j = 0; j < 2; j++) begin
        if (grant[j+1])
          wait_cnt[j] <= '0;
        else if (candidate[j+1] && (wait_cnt[j] != LIMIT_CNT))
          wait_cnt[j] <= wait_cnt[j] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      port_out[i].mem_ready = clear[i];
      port_out[i].mem_rdata = clear[i] ? bus.memory_rdata : 32'h0;
    end
  end

  assign bus.dmem_out     = port_out[0];
  assign bus.imem_out     = port_out[1];
  assign bus.aux_out      = port_out[2];
  assign bus.memory_valid = cur.mem_valid;
  assign bus.memory_instr = cur.mem_instr;
  assign bus.memory_addr  = cur.mem_addr;
  assign bus.memory_wdata = cur.mem_wdata;
  assign bus.memory_wstrb = cur.mem_wstrb;
  assign bus.grant_owner  = owner;
  assign bus.overflow     = overflow;

endmodule
